keypad_scanner: RTL and testbench

Drives the 4×4 keypad column strobes and samples the rows. Debounces each press and release, then encodes the pressed key into the team's 4-bit key code. Delivers each key through a single-entry valid/ack register. It is the driving end of the keypad interface: it produces the `kpc` column pattern and consumes the `kpr` row lines that the keypad decode logic interprets.

---
 rtl/keypad_scanner.sv | 230 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with debounce, key encoding and valid/ack output.
// Define KP_REPEAT_EN to enable auto-repeat of a held key.
module keypad_scanner #(
   parameter int DWELL        = 50000,
   parameter int DEBOUNCE     = 8,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] kpr,
   output logic [3:0] kpc,
   output logic [3:0] key,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_down,
   output logic       overrun
);

   typedef enum logic [1:0] {SCAN, CONFIRM, HELD} state_t;

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int CW = $clog2(DEBOUNCE + 1);

   if (DWELL < 4 || DEBOUNCE < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
   begin : g_bad_param
      $error("keypad_scanner: parameter out of range");
   end

   logic [3:0]    kpr_m;
   logic [3:0]    kpr_s;
   logic [DW-1:0] div;
   logic          tick;
   state_t        state;
   state_t        state_nxt;
   logic [1:0]    col;
   logic [1:0]    col_nxt;
   logic [3:0]    row;
   logic [3:0]    row_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [CW-1:0] cnt_inc;
   logic          down_nxt;
   logic          emit;
   logic          one_cold;
   logic [3:0]    code;

`ifdef KP_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                      : REPEAT_RATE;
   localparam int HW = $clog2(RMAX + 1);

   logic [HW-1:0] hold;
   logic [HW-1:0] hold_nxt;
   logic [HW-1:0] hold_inc;
   logic          armed;
   logic          armed_nxt;
`endif

   function automatic logic [3:0] key_code(input logic [3:0] r,
                                           input logic [1:0] c);
      logic [1:0] ri;
      logic [3:0] k;
      case (r)
         4'b0111: ri = 2'd0;
         4'b1011: ri = 2'd1;
         4'b1101: ri = 2'd2;
         default: ri = 2'd3;
      endcase
      case ({ri, c})
         4'd0:    k = 4'h1;
         4'd1:    k = 4'h2;
         4'd2:    k = 4'h3;
         4'd3:    k = 4'hA;
         4'd4:    k = 4'h4;
         4'd5:    k = 4'h5;
         4'd6:    k = 4'h6;
         4'd7:    k = 4'hB;
         4'd8:    k = 4'h7;
         4'd9:    k = 4'h8;
         4'd10:   k = 4'h9;
         4'd11:   k = 4'hC;
         4'd12:   k = 4'hE;
         4'd13:   k = 4'h0;
         4'd14:   k = 4'hF;
         default: k = 4'hD;
      endcase
      return k;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         kpr_m <= 4'hF;
         kpr_s <= 4'hF;
      end else begin
         kpr_m <= kpr;
         kpr_s <= kpr_m;
      end
   end

   assign tick = (div == DW'(DWELL - 1));

   always_ff @(posedge clk) begin
      if (reset)     div <= '0;
      else if (tick) div <= '0;
      else           div <= div + DW'(1);
   end

   assign one_cold = (kpr_s == 4'b0111) || (kpr_s == 4'b1011) ||
                     (kpr_s == 4'b1101) || (kpr_s == 4'b1110);
   assign cnt_inc  = cnt + CW'(1);
   assign code     = key_code(row, col);
   assign kpc      = ~(4'b1000 >> col);

   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      row_nxt   = row;
      cnt_nxt   = cnt;
      down_nxt  = key_down;
      emit      = 1'b0;
`ifdef KP_REPEAT_EN
      hold_nxt  = hold;
      armed_nxt = armed;
      hold_inc  = hold + HW'(1);
`endif
      if (tick) begin
         case (state)
            SCAN: begin
               if (one_cold) begin
                  row_nxt   = kpr_s;
                  cnt_nxt   = CW'(1);
                  state_nxt = CONFIRM;
               end else begin
                  col_nxt = col + 2'd1;
               end
            end
            CONFIRM: begin
               if (kpr_s == row) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == CW'(DEBOUNCE)) begin
                     emit      = 1'b1;
                     down_nxt  = 1'b1;
                     cnt_nxt   = '0;
                     state_nxt = HELD;
`ifdef KP_REPEAT_EN
                     hold_nxt  = '0;
                     armed_nxt = 1'b0;
`endif
                  end
               end else begin
                  state_nxt = SCAN;
               end
            end
            HELD: begin
               if (kpr_s == 4'hF) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc == CW'(DEBOUNCE)) begin
                     cnt_nxt   = '0;
                     down_nxt  = 1'b0;
                     col_nxt   = col + 2'd1;
                     state_nxt = SCAN;
                  end
               end else begin
                  cnt_nxt = '0;
               end
`ifdef KP_REPEAT_EN
               // Repeat only while the key itself is still seen.
               if (kpr_s == row) begin
                  hold_nxt = hold_inc;
                  if (!armed && hold_inc == HW'(REPEAT_DELAY)) begin
                     emit      = 1'b1;
                     armed_nxt = 1'b1;
                     hold_nxt  = '0;
                  end else if (armed && hold_inc == HW'(REPEAT_RATE)) begin
                     emit     = 1'b1;
                     hold_nxt = '0;
                  end
               end
`endif
            end
            default: state_nxt = SCAN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= SCAN;
         col      <= 2'd0;
         row      <= 4'hF;
         cnt      <= '0;
         key_down <= 1'b0;
      end else begin
         state    <= state_nxt;
         col      <= col_nxt;
         row      <= row_nxt;
         cnt      <= cnt_nxt;
         key_down <= down_nxt;
      end
   end

`ifdef KP_REPEAT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         hold  <= '0;
         armed <= 1'b0;
      end else begin
         hold  <= hold_nxt;
         armed <= armed_nxt;
      end
   end
`endif

   // An ack landing with an emit consumes the old key, so no overrun.
   always_ff @(posedge clk) begin
      if (reset) begin
         key       <= 4'h0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (emit) begin
         key       <= code;
         key_valid <= 1'b1;
         if (key_valid && !key_ack) overrun <= 1'b1;
      end else if (key_valid && key_ack) begin
         key_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with DWELL=4, DEBOUNCE=3.
// Define KP_REPEAT_EN for both files to also exercise auto-repeat.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] kpr;
   logic [3:0] kpc;
   logic [3:0] key;
   logic       key_valid;
   logic       key_ack;
   logic       key_down;
   logic       overrun;

   logic       press_en = 1'b0;
   logic [1:0] pr = 2'd0;
   logic [1:0] pc = 2'd0;
   logic       ghost = 1'b0;
   logic       man_ack = 1'b0;
   logic       auto_ack = 1'b0;
   logic       auto_r = 1'b0;
   logic       prev_valid = 1'b0;

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   logic [3:0] sb[$];
   int         rise_t[$];

   keypad_scanner #(
      .DWELL(4),
      .DEBOUNCE(3),
      .REPEAT_DELAY(5),
      .REPEAT_RATE(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .kpr(kpr),
      .kpc(kpc),
      .key(key),
      .key_valid(key_valid),
      .key_ack(key_ack),
      .key_down(key_down),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   assign kpr = ghost ? 4'b0011 :
                (press_en && !kpc[2'd3 - pc]) ? ~(4'b1000 >> pr) : 4'hF;
   assign key_ack = auto_ack ? auto_r : man_ack;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (key_valid && !prev_valid) begin
         rise_t.push_back(cyc);
         if (sb.size() == 0) chk("sb_extra", sb.size(), 1);
         else                chk("sb_key", key, sb.pop_front());
      end
      prev_valid = key_valid;
      auto_r     = key_valid;
   end

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic hold_key(input logic [1:0] r, input logic [1:0] c);
      pr       = r;
      pc       = c;
      press_en = 1'b1;
   endtask

   task automatic wait_valid(input string tag);
      for (int n = 0; n < 200 && !key_valid; n++) @(negedge clk);
      chk(tag, key_valid, 1);
   endtask

   task automatic wait_down(input string tag, input logic lvl);
      for (int n = 0; n < 200 && key_down !== lvl; n++) @(negedge clk);
      chk(tag, key_down, lvl);
   endtask

   task automatic pulse_ack();
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
   endtask

   initial begin
      int n;
      logic [3:0] exp_kpc;

      // Idle rotation after reset
      do_reset();
      for (int i = 0; i < 20; i++) begin
         exp_kpc = ~(4'b1000 >> ((i / 4) % 4));
         chk("idle_kpc", kpc, exp_kpc);
         chk("idle_out", {key, key_valid, key_down, overrun}, 0);
         @(negedge clk);
      end

      // Key '5' with latency, freeze, ack, release
      sb.push_back(4'h5);
      hold_key(2'd1, 2'd1);
      do_reset();
      for (n = 0; n < 50 && kpc != 4'b1011; n++) @(negedge clk);
      chk("col1_reach", kpc, 4'b1011);
      for (n = 0; n < 100 && !key_valid; n++) @(negedge clk);
      chk("lat5", n, 12);
      chk("frz5", kpc, 4'b1011);
      chk("down5", key_down, 1);
      pulse_ack();
      chk("ack5", key_valid, 0);
      press_en = 1'b0;
      wait_down("rel5", 1'b0);
      chk("resume5", kpc, 4'b1101);

      // Bounce: two matching ticks, then released
      hold_key(2'd0, 2'd0);
      do_reset();
      repeat (8) @(negedge clk);
      press_en = 1'b0;
      repeat (5) @(negedge clk);
      chk("bnc_hold", kpc, 4'b0111);
      repeat (3) @(negedge clk);
      chk("bnc_go", kpc, 4'b1011);
      repeat (40) @(negedge clk);
      chk("bnc_valid", key_valid, 0);
      chk("bnc_down", key_down, 0);

      // Same-cycle ack/emit, then overrun
      sb.push_back(4'h1);
      hold_key(2'd0, 2'd0);
      do_reset();
      wait_valid("ov_1");
      press_en = 1'b0;
      wait_down("ov_rel1", 1'b0);
      hold_key(2'd0, 2'd2);
      for (n = 0; n < 50 && kpc != 4'b1101; n++) @(negedge clk);
      chk("col2_reach", kpc, 4'b1101);
      repeat (11) @(negedge clk);
      pulse_ack();
      chk("sca_key", key, 4'h3);
      chk("sca_valid", key_valid, 1);
      chk("sca_ov", overrun, 0);
      press_en = 1'b0;
      wait_down("ov_rel3", 1'b0);
      hold_key(2'd3, 2'd3);
      wait_down("ov_dn", 1'b1);
      chk("ov_key", key, 4'hD);
      chk("ov_valid", key_valid, 1);
      chk("ov_flag", overrun, 1);
      pulse_ack();
      press_en = 1'b0;
      wait_down("ov_relD", 1'b0);
      chk("ov_sticky", overrun, 1);
      chk("ov_clr", key_valid, 0);

      // Ghost pattern on every column
      ghost = 1'b1;
      do_reset();
      repeat (20) @(negedge clk);
      chk("ghost_c1", kpc, 4'b1011);
      repeat (20) @(negedge clk);
      chk("ghost_c2", kpc, 4'b1101);
      chk("ghost_out", {key_valid, key_down, overrun}, 0);
      ghost = 1'b0;

`ifdef KP_REPEAT_EN
      // Auto-repeat of 'A' with every event acked
      auto_ack = 1'b1;
      repeat (4) sb.push_back(4'hA);
      hold_key(2'd0, 2'd3);
      do_reset();
      rise_t.delete();
      for (n = 0; n < 400 && rise_t.size() < 4; n++) @(negedge clk);
      press_en = 1'b0;
      chk("rpt_cnt", rise_t.size(), 4);
      chk("rpt_gap1", rise_t[1] - rise_t[0], 20);
      chk("rpt_gap2", rise_t[2] - rise_t[1], 8);
      chk("rpt_gap3", rise_t[3] - rise_t[2], 8);
      wait_down("rpt_rel", 1'b0);
      repeat (20) @(negedge clk);
      chk("rpt_total", rise_t.size(), 4);
      auto_ack = 1'b0;
`endif

      chk("sb_left", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
